ifu_fetch: RTL
==============

# ifu_fetch

Multi-cycle instruction fetch unit for the NPC core. It issues one instruction-memory read per instruction over a valid/ready request channel and captures the response. It presents the instruction and its PC to the decode stage (idu) through a valid/ready handshake, then waits for execute to return the next PC. It replaces the combinational fetcher once instruction memory has non-zero latency.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_o  out  1  memory read request valid
- req_ready_i  in  1  memory accepts request
- req_addr_o  out  XLEN  request address (= current PC)
- rsp_valid_i  in  1  read response valid (single-cycle pulse)
- rsp_data_i  in  32  instruction word
- rsp_err_i  in  1  bus error on this response
- inst_valid_o  out  1  fetched instruction valid to decode
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  instruction word
- pc_o  out  XLEN  PC of inst_o
- inst_err_o  out  1  fetch fault (bus error or misaligned PC)
- npc_valid_i  in  1  execute delivers next PC
- npc_i  in  XLEN  next PC
- fetch_cnt_o  out  32  count of instructions handed to decode

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD, WAIT_NPC.
- BOOT: entered on reset. Next cycle goes to REQ.
- REQ: req_valid_o=1 and req_addr_o=pc.
  - On req_valid_o&&req_ready_i, go to WAIT.
  - If pc[1:0]!=0, no request is issued (req_valid_o=0). Instead: inst_o=0, inst_err_o=1, go to HOLD.
- WAIT: on rsp_valid_i, capture inst_o=rsp_data_i and inst_err_o=rsp_err_i, then go to HOLD.
- HOLD: inst_valid_o=1. inst_o, pc_o and inst_err_o are stable until handshake.
  - On inst_valid_o&&inst_ready_i: go to WAIT_NPC, and fetch_cnt_o increments (wraps 2^32-1 -> 0).
- WAIT_NPC: on npc_valid_i, pc<=npc_i, then go to REQ.
- Ignored inputs:
  - rsp_valid_i is ignored outside WAIT.
  - npc_valid_i is ignored outside WAIT_NPC.
  - req_ready_i is ignored outside REQ.
- Outstanding requests: at most one at any time. No speculation and no sequential prefetch.
- pc_o always equals the internal pc register. req_addr_o=pc.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_PC.
  - req_valid_o=0, inst_valid_o=0, inst_o=0, inst_err_o=0, fetch_cnt_o=0.
  - pc_o=req_addr_o=RESET_PC.
- First request: req_valid_o=1 in the second cycle after rst_i deasserts (BOOT occupies one cycle).
- Memory contract: the earliest response is the cycle after request acceptance. A same-cycle response is illegal and is ignored.
- Minimum latency, npc_valid_i sampled at edge t to inst_valid_o high: 3 cycles (REQ t+1, WAIT t+2 with rsp, HOLD t+3).
- Misaligned-PC latency: 1 cycle (REQ -> HOLD).
- Back-pressure: inst_valid_o stays high indefinitely while inst_ready_i=0. There is no combinational path from inst_ready_i to inst_valid_o.
- Reset mid-operation: returns to BOOT immediately; any in-flight request is abandoned. Instruction memory must share rst_i so stale responses cannot arrive.
- Simultaneous rsp_valid_i and rsp_err_i: data is captured and the error is flagged; decode treats the word as invalid.

## Structure
- liang_pkg additions:
  - ifu_state_e enum (BOOT, REQ, WAIT, HOLD, WAIT_NPC).
  - RESET_PC constant.
  - Existing inst_t/pc_t are reused for inst_o/pc_o.
- Single module, no sub-modules. The module contains:
  - one FSM;
  - the pc, instruction and error capture registers;
  - fetch_cnt_o.
- top instantiates ifu_fetch in place of inst_fetcher.
  - The top-level pc_r register moves into this block.
  - npc_src1+npc_src2 drives npc_i.

## Test plan
- Reset, req_ready_i=1, 1-cycle memory returning 32'h00000013 -> req_addr_o=32'h80000000 in 2nd cycle after reset; inst_valid_o high 2 cycles later with pc_o=32'h80000000, inst_o=32'h00000013.
- Hold inst_ready_i=0 for 5 cycles -> inst_valid_o, inst_o, pc_o stable; fetch_cnt_o stays 0; raising inst_ready_i -> fetch_cnt_o=1 next cycle.
- npc_i=32'h80000100, req_ready_i low 3 cycles, 4-cycle response latency -> exactly one accepted request with addr 32'h80000100; inst_valid_o asserted the cycle after rsp_valid_i.
- npc_i=32'h80000102 -> req_valid_o never asserts; HOLD next cycle with inst_err_o=1, inst_o=0, pc_o=32'h80000102.
- rsp_err_i=1 with rsp_data_i=32'hDEADBEEF -> inst_err_o=1, inst_o=32'hDEADBEEF; spurious rsp_valid_i/npc_valid_i in HOLD have no effect.
- Assert rst_i while in WAIT -> all outputs return to reset values asynchronously; fetch restarts at 32'h80000000.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared NPC core types: instruction/PC words and the fetch FSM encoding.
// Imported by ifu_fetch; no ports.
package liang_pkg;

  localparam int XLEN = 32;

  typedef logic [31:0]     inst_t;
  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    WAIT_NPC
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: one imem read per instruction, held for
// decode until accepted, then waits for execute to supply the next PC.
// Ports: clk_i/rst_i (async, active-high); req_* imem request channel;
// rsp_* imem response; inst_*/pc_o decode handshake; npc_* next PC in;
// fetch_cnt_o counts instructions accepted by decode.
module ifu_fetch
  import liang_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [31:0]     rsp_data_i,
  input  logic            rsp_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output inst_t           inst_o,
  output pc_t             pc_o,
  output logic            inst_err_o,
  input  logic            npc_valid_i,
  input  logic [XLEN-1:0] npc_i,
  output logic [31:0]     fetch_cnt_o
);

  ifu_state_e  state_q, state_d;
  pc_t         pc_q, pc_d;
  inst_t       inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_valid_o  = 1'b0;
    inst_valid_o = 1'b0;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        // A misaligned PC faults locally and never reaches memory.
        if (misaligned) begin
          inst_d  = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          req_valid_o = 1'b1;
          if (req_ready_i) state_d = WAIT;
        end
      end
      WAIT: begin
        if (rsp_valid_i) begin
          inst_d  = rsp_data_i;
          err_d   = rsp_err_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        inst_valid_o = 1'b1;
        if (inst_ready_i) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = WAIT_NPC;
        end
      end
      WAIT_NPC: begin
        if (npc_valid_i) begin
          pc_d    = npc_i;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign req_addr_o  = pc_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;
  assign inst_err_o  = err_q;
  assign fetch_cnt_o = cnt_q;

endmodule
